// File: rtl/if_id_pkg.sv
// Shared types and defaults for the fetch/decode skid stage.
// Imported by if_id_skid.
package if_id_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 14;

    localparam logic [DATA_W_DEF-1:0] NOP_WORD_DEF = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-high clear.
// Used for the optional stage statistics.
module sat_counter #(
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inc,
    output logic [COUNT_W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/if_id_skid.sv
// Fetch/decode register with valid/ready and a 2-entry skid buffer.
// Optional stall/bubble counters under IF_ID_SKID_STATS_EN.
module if_id_skid
    import if_id_pkg::*;
#(
    parameter int              DATA_W   = DATA_W_DEF,
    parameter int              ADDR_W   = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF),
    parameter int              COUNT_W  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_instr,
    input  logic [ADDR_W-1:0]  in_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_instr,
    output logic [ADDR_W-1:0]  out_addr
`ifdef IF_ID_SKID_STATS_EN
    ,
    output logic [COUNT_W-1:0] stall_count,
    output logic [COUNT_W-1:0] bubble_count
`endif
);

    state_t state_q, state_d;

    logic [DATA_W-1:0] main_instr_q, main_instr_d;
    logic [ADDR_W-1:0] main_addr_q,  main_addr_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_addr_q,  skid_addr_d;

    logic ready_q;
    logic valid_q;
    logic accept;
    logic retire;

    assign accept = in_valid & ready_q;
    assign retire = valid_q & out_ready;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_addr_d  = main_addr_q;
        skid_instr_d = skid_instr_q;
        skid_addr_d  = skid_addr_q;
        if (flush) begin
            state_d      = EMPTY;
            main_instr_d = '0;
            main_addr_d  = '0;
            skid_instr_d = '0;
            skid_addr_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d      = ONE;
                        main_instr_d = in_instr;
                        main_addr_d  = in_addr;
                    end
                end
                ONE: begin
                    unique case (1'b1)
                        accept & retire: begin
                            main_instr_d = in_instr;
                            main_addr_d  = in_addr;
                        end
                        accept & ~retire: begin
                            state_d      = TWO;
                            skid_instr_d = in_instr;
                            skid_addr_d  = in_addr;
                        end
                        ~accept & retire: begin
                            state_d      = EMPTY;
                            main_instr_d = '0;
                            main_addr_d  = '0;
                        end
                        default: ;
                    endcase
                end
                TWO: begin
                    if (retire) begin
                        state_d      = ONE;
                        main_instr_d = skid_instr_q;
                        main_addr_d  = skid_addr_q;
                        skid_instr_d = '0;
                        skid_addr_d  = '0;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Handshake flags are flopped from next state: no out_ready->in_ready path.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            main_instr_q <= '0;
            main_addr_q  <= '0;
            skid_instr_q <= '0;
            skid_addr_q  <= '0;
            ready_q      <= 1'b1;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_addr_q  <= main_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_addr_q  <= skid_addr_d;
            ready_q      <= (state_d != TWO);
            valid_q      <= (state_d != EMPTY);
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_instr = valid_q ? main_instr_q : NOP_WORD;
    assign out_addr  = valid_q ? main_addr_q  : '0;

`ifdef IF_ID_SKID_STATS_EN
    sat_counter #(
        .COUNT_W(COUNT_W)
    ) u_stall (
        .clock(clock),
        .reset(reset),
        .inc  (valid_q & ~out_ready),
        .count(stall_count)
    );

    sat_counter #(
        .COUNT_W(COUNT_W)
    ) u_bubble (
        .clock(clock),
        .reset(reset),
        .inc  (~valid_q & out_ready),
        .count(bubble_count)
    );
`else
    logic unused_count_w;
    assign unused_count_w = ^COUNT_W;
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: directed cases plus random traffic
// checked against a queue model of a 2-deep FIFO.
module tb_if_id_skid;

    localparam int DW = 32;
    localparam int AW = 14;
    localparam int CW = 4;

    logic          clock;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_instr;
    logic [AW-1:0] in_addr;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_addr;
`ifdef IF_ID_SKID_STATS_EN
    logic [CW-1:0] stall_count;
    logic [CW-1:0] bubble_count;
`endif

    if_id_skid #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .COUNT_W(CW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .in_addr  (in_addr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_addr (out_addr)
`ifdef IF_ID_SKID_STATS_EN
        ,
        .stall_count (stall_count),
        .bubble_count(bubble_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [DW+AW-1:0] q[$];
    int stall_m  = 0;
    int bubble_m = 0;
    int max_cnt  = (1 << CW) - 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic exp_out(input string name, input logic v,
                           input logic [DW-1:0] i, input logic [AW-1:0] a,
                           input logic r);
        chk({name, ".valid"}, 64'(out_valid), 64'(v));
        chk({name, ".instr"}, 64'(out_instr), 64'(i));
        chk({name, ".addr"},  64'(out_addr),  64'(a));
        chk({name, ".ready"}, 64'(in_ready),  64'(r));
    endtask

    task automatic model_update();
        bit acc, ret;
        acc = in_valid && (q.size() < 2);
        ret = (q.size() > 0) && out_ready;
        if ((q.size() > 0) && !out_ready && stall_m < max_cnt) stall_m++;
        if ((q.size() == 0) && out_ready && bubble_m < max_cnt) bubble_m++;
        if (flush) begin
            q.delete();
        end else begin
            if (ret) void'(q.pop_front());
            if (acc) q.push_back({in_instr, in_addr});
        end
    endtask

    task automatic compare_all();
        logic          v, r;
        logic [DW-1:0] i;
        logic [AW-1:0] a;
        v = q.size() > 0;
        r = q.size() < 2;
        i = v ? q[0][AW +: DW] : '0;
        a = v ? q[0][AW-1:0] : '0;
        exp_out("model", v, i, a, r);
`ifdef IF_ID_SKID_STATS_EN
        chk("model.stall",  64'(stall_count),  64'(stall_m));
        chk("model.bubble", 64'(bubble_count), 64'(bubble_m));
`endif
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        @(negedge clock);
        compare_all();
    endtask

    task automatic push(input logic [DW-1:0] i, input logic [AW-1:0] a);
        in_valid = 1'b1;
        in_instr = i;
        in_addr  = a;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_instr = '0;
        in_addr  = '0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        exp_out("rst_async", 1'b0, '0, '0, 1'b1);
`ifdef IF_ID_SKID_STATS_EN
        chk("rst_stall", 64'(stall_count), 64'd0);
`endif
        q.delete();
        stall_m  = 0;
        bubble_m = 0;
        idle();
        flush = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        idle();
        #1;
        exp_out("rst_init", 1'b0, '0, '0, 1'b1);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        out_ready = 1'b1;
        push(32'h11111111, 14'h1);
        step(); exp_out("stream1", 1, 32'h11111111, 14'h1, 1);
        push(32'h22222222, 14'h2);
        step(); exp_out("stream2", 1, 32'h22222222, 14'h2, 1);
        push(32'h33333333, 14'h3);
        step(); exp_out("stream3", 1, 32'h33333333, 14'h3, 1);
        idle();
        step(); exp_out("stream_end", 0, '0, '0, 1);

        out_ready = 1'b0;
        push(32'hAAAA0001, 14'h1);
        step(); exp_out("bp_a", 1, 32'hAAAA0001, 14'h1, 1);
        push(32'hBBBB0002, 14'h2);
        step(); exp_out("bp_full", 1, 32'hAAAA0001, 14'h1, 0);
        idle();
        step(); exp_out("bp_hold", 1, 32'hAAAA0001, 14'h1, 0);
        out_ready = 1'b1;
        step(); exp_out("bp_b", 1, 32'hBBBB0002, 14'h2, 1);
        step(); exp_out("bp_empty", 0, '0, '0, 1);

        out_ready = 1'b0;
        push(32'hAAAA0001, 14'h1);
        step();
        push(32'hBBBB0002, 14'h2);
        step(); exp_out("fl_two", 1, 32'hAAAA0001, 14'h1, 0);
        push(32'hCCCC0003, 14'h3);
        flush = 1'b1;
        step(); exp_out("fl_clear", 0, '0, '0, 1);
        flush = 1'b0;
        idle();
        out_ready = 1'b1;
        step(); exp_out("fl_no_c", 0, '0, '0, 1);

        out_ready = 1'b0;
        push(32'hAAAA0001, 14'h1);
        step(); exp_out("sim_a", 1, 32'hAAAA0001, 14'h1, 1);
        out_ready = 1'b1;
        push(32'hDDDD0004, 14'h4);
        step(); exp_out("sim_d", 1, 32'hDDDD0004, 14'h4, 1);
        idle();
        step(); exp_out("sim_empty", 0, '0, '0, 1);

        out_ready = 1'b0;
        push(32'hAAAA0001, 14'h1);
        step();
        push(32'hBBBB0002, 14'h2);
        step(); exp_out("rs_two", 1, 32'hAAAA0001, 14'h1, 0);
        do_reset();
        step(); exp_out("rs_after", 0, '0, '0, 1);

        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_instr  = $urandom;
            in_addr   = AW'($urandom);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(15) == 0);
            step();
        end
        flush = 1'b0;
        idle();

`ifdef IF_ID_SKID_STATS_EN
        do_reset();
        out_ready = 1'b0;
        push(32'hAAAA0001, 14'h1);
        step();
        idle();
        repeat (20) step();
        chk("stall_sat", 64'(stall_count), 64'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("stall_flush", 64'(stall_count), 64'd15);
        do_reset();
        chk("stall_reset", 64'(stall_count), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
- Parametrised successor to the fetch/decode pipeline register.
- Holds the instruction word and its return address between Instruction Fetch and Instruction Decode.
- Replaces the single stall input with a valid/ready handshake on both sides, backed by a 2-entry skid buffer, so that in_ready is a registered signal.
- Adds a synchronous flush for branch and jump squash; a flushed or empty stage presents NOP_WORD to decode.

Parameters:
- DATA_W, 32, instruction word width
- ADDR_W, 14, return address width
- NOP_WORD, {DATA_W{1'b0}}, word driven on out_instr whenever out_valid=0
- COUNT_W, 16, width of the statistics counters (used only with the optional feature)

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  fetch presents a word
- in_ready  out  1  stage can accept a word; registered output
- in_instr  in  DATA_W  instruction word from the program memory read port
- in_addr  in  ADDR_W  return address from fetch
- out_valid  out  1  decode-side word valid
- out_ready  in  1  decode accepts the word
- out_instr  out  DATA_W  instruction word to decode
- out_addr  out  ADDR_W  return address to decode

Behaviour:
- Transfers: accept = in_valid & in_ready; retire = out_valid & out_ready.
- Reset (async, active-high):
  - state = EMPTY, in_ready = 1, out_valid = 0
  - out_instr = NOP_WORD, out_addr = 0, skid entry cleared
- State machine (main register + skid register):
  - EMPTY:
    - accept -> ONE; main loads in_instr/in_addr; out_valid = 1 next cycle (latency 1).
  - ONE:
    - accept & retire -> ONE; main reloads (full throughput, 1 word/cycle).
    - accept only -> TWO; skid loads; in_ready = 0 next cycle.
    - retire only -> EMPTY.
    - neither -> hold.
  - TWO (in_ready = 0, so accept is impossible):
    - retire -> ONE; main loads from skid; skid cleared; in_ready = 1 next cycle.
    - no retire -> hold.
- Ordering: strict FIFO order; no word is ever dropped or duplicated except by flush.
- Stability: while out_valid & !out_ready, out_instr and out_addr hold stable.
- Bubble output: when out_valid = 0, out_instr = NOP_WORD and out_addr = 0.
- Flush:
  - Highest priority after reset.
  - Next state = EMPTY; main and skid cleared; out_instr = NOP_WORD; out_valid = 0; in_ready = 1.
  - A word accepted in the flush cycle is discarded.
  - A retire in the flush cycle still counts as consumed by decode.
- in_ready depends only on state; there is no combinational path from out_ready to in_ready.
- Reset asserted mid-operation: all entries are lost immediately, without waiting for a clock edge.

Optional Feature:
- Macro: IF_ID_SKID_STATS_EN
- With the macro defined:
  - Adds output stall_count [COUNT_W-1:0]: increments each cycle out_valid & !out_ready.
  - Adds output bubble_count [COUNT_W-1:0]: increments each cycle !out_valid & out_ready.
  - Both counters saturate at all-ones, clear on reset, and are unaffected by flush.
- Without the macro: the ports and counters are absent; the stage behaves identically otherwise.

Decomposition:
- Package if_id_pkg:
  - State encoding localparams (EMPTY=2'd0, ONE=2'd1, TWO=2'd2)
  - Default DATA_W/ADDR_W
  - Default NOP_WORD constant
- Sub-module: sat_counter (parameter COUNT_W; ports clock, reset, inc, count). Instantiated twice under IF_ID_SKID_STATS_EN.

Test Plan:
- Reset check: assert reset mid-stream with the stage holding two entries -> immediately out_valid=0, out_instr=NOP_WORD (0x00000000), out_addr=0, in_ready=1.
- Streaming: out_ready=1, push 0x11111111/0x0001, 0x22222222/0x0002, 0x33333333/0x0003 on consecutive cycles -> each appears on out_* exactly 1 cycle after acceptance, no gaps, in_ready stays 1.
- Backpressure: out_ready=0 while pushing A=0xAAAA0001 and B=0xBBBB0002 -> after B is accepted, in_ready=0 and out_instr holds A. Raise out_ready -> A retires, then B retires, and in_ready returns to 1 one cycle after A retires.
- Flush in TWO: stage holds A and B, assert flush with in_valid=1 and C=0xCCCC0003 -> next cycle out_valid=0, out_instr=0; C never appears on the output.
- Simultaneous accept/retire in ONE: A held, out_ready=1, push D=0xDDDD0004 -> next cycle out_instr=D, state stays ONE, in_ready=1.
- Stats (IF_ID_SKID_STATS_EN, COUNT_W=4): hold out_valid=1 with out_ready=0 for 20 cycles -> stall_count saturates at 15; apply flush -> count stays 15; apply reset -> count = 0.
